// File: rtl/map_arb_pkg.sv
// Shared types for the map port arbiter: FSM states, corner indices and read tags.
package map_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic [1:0] TL = 2'd0;
  localparam logic [1:0] TR = 2'd1;
  localparam logic [1:0] BL = 2'd2;
  localparam logic [1:0] BR = 2'd3;

  localparam logic TAG_PIX = 1'b0;
  localparam logic TAG_COL = 1'b1;

endpackage

// File: rtl/map_addr_calc.sv
// Map coordinate to row-major bit address plus out-of-map flag (combinational).
module map_addr_calc
  import map_arb_pkg::*;
#(
  parameter int MAP_WIDTH_X = 100,
  parameter int MAP_WIDTH_Y = 100,
  parameter int ADDR_W      = 14,
  parameter int CW          = 11
) (
  input  logic [CW-1:0]     x,
  input  logic [CW-1:0]     y,
  output logic              oob,
  output logic [ADDR_W-1:0] addr
);

  assign oob  = (32'(x) >= 32'(MAP_WIDTH_X)) || (32'(y) >= 32'(MAP_WIDTH_Y));
  assign addr = ADDR_W'(32'(y) * 32'(MAP_WIDTH_X) + 32'(x));

endmodule

// File: rtl/map_port_arbiter.sv
// Single-port map memory arbiter: fixed-latency pixel reads win, collision probes use spare slots.
// Optional stall statistics output enabled by defining MAP_ARB_STATS_EN.
module map_port_arbiter
  import map_arb_pkg::*;
#(
  parameter int MAP_WIDTH_X = 100,
  parameter int MAP_WIDTH_Y = 100,
  parameter int ADDR_W      = 14,
  parameter int COORD_W     = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_tick,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               map_on,
  output logic               pix_valid,
  output logic               pix_bit,
  input  logic               col_req,
  input  logic [COORD_W-1:0] col_x,
  input  logic [COORD_W-1:0] col_y,
  input  logic [COORD_W-1:0] col_w,
  input  logic [COORD_W-1:0] col_h,
  output logic               col_busy,
  output logic               col_done,
  output logic [3:0]         col_hit,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
`ifdef MAP_ARB_STATS_EN
  output logic [15:0]        col_stall_cnt,
`endif
  input  logic               mem_rdata
);

  arb_state_e state_r, state_s;
  logic [COORD_W:0] x0_r, x1_r, y0_r, y1_r, cx_s, cy_s, x1_s, y1_s;
  logic [COORD_W-1:0] w_eff_s, h_eff_s;
  logic [1:0] corner_r, idx_a_r, idx_b_r;
  logic [3:0] hit_r;
  logic mem_en_r, tag_a_r, rd_b_r, tag_b_r;
  logic [ADDR_W-1:0] mem_addr_r, pix_addr_s, cor_addr_s;
  logic pv1_r, pv2_r, pix_valid_r, pix_bit_r, col_busy_r, col_done_r;
  logic pix_oob_s, cor_oob_s, pix_issue_s, col_want_s, col_issue_s, col_blocked_s;
  logic corner_adv_s, accept_s;

  map_addr_calc #(.MAP_WIDTH_X(MAP_WIDTH_X), .MAP_WIDTH_Y(MAP_WIDTH_Y), .ADDR_W(ADDR_W), .CW(COORD_W + 1))
    u_pix_addr (.x({1'b0, pix_x}), .y({1'b0, pix_y}), .oob(pix_oob_s), .addr(pix_addr_s));

  map_addr_calc #(.MAP_WIDTH_X(MAP_WIDTH_X), .MAP_WIDTH_Y(MAP_WIDTH_Y), .ADDR_W(ADDR_W), .CW(COORD_W + 1))
    u_cor_addr (.x(cx_s), .y(cy_s), .oob(cor_oob_s), .addr(cor_addr_s));

  // Zero-size boxes collapse to a single cell; one extra bit keeps far corners from wrapping.
  assign w_eff_s = (col_w == {COORD_W{1'b0}}) ? {{(COORD_W-1){1'b0}}, 1'b1} : col_w;
  assign h_eff_s = (col_h == {COORD_W{1'b0}}) ? {{(COORD_W-1){1'b0}}, 1'b1} : col_h;
  assign x1_s = {1'b0, col_x} + {1'b0, w_eff_s} - {{COORD_W{1'b0}}, 1'b1};
  assign y1_s = {1'b0, col_y} + {1'b0, h_eff_s} - {{COORD_W{1'b0}}, 1'b1};

  assign pix_issue_s   = pix_tick & map_on & ~pix_oob_s;
  assign col_want_s    = (state_r == ISSUE) & ~cor_oob_s;
  assign col_issue_s   = col_want_s & ~pix_issue_s;
  assign col_blocked_s = col_want_s & pix_issue_s;
  assign corner_adv_s  = (state_r == ISSUE) & ~col_blocked_s;
  assign accept_s      = (state_r == IDLE) & col_req;

  // Corner coordinate select for the current probe corner.
  always_comb begin
    cx_s = x0_r;
    cy_s = y0_r;
    case (corner_r)
      TL:      begin cx_s = x0_r; cy_s = y0_r; end
      TR:      begin cx_s = x1_r; cy_s = y0_r; end
      BL:      begin cx_s = x0_r; cy_s = y1_r; end
      BR:      begin cx_s = x1_r; cy_s = y1_r; end
      default: begin cx_s = x0_r; cy_s = y0_r; end
    endcase
  end

  // Probe FSM next state; DRAIN ends once no collision read sits in the issue stage.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (col_req) state_s = ISSUE; else state_s = IDLE;
      ISSUE:   if (corner_adv_s && corner_r == BR) state_s = DRAIN; else state_s = ISSUE;
      DRAIN:   if (!(mem_en_r && tag_a_r == TAG_COL)) state_s = DONE; else state_s = DRAIN;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Memory issue/return pipeline, pixel pipeline and probe bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      x0_r        <= '0;
      x1_r        <= '0;
      y0_r        <= '0;
      y1_r        <= '0;
      corner_r    <= TL;
      hit_r       <= 4'd0;
      mem_en_r    <= 1'b0;
      mem_addr_r  <= '0;
      tag_a_r     <= TAG_PIX;
      idx_a_r     <= TL;
      rd_b_r      <= 1'b0;
      tag_b_r     <= TAG_PIX;
      idx_b_r     <= TL;
      pv1_r       <= 1'b0;
      pv2_r       <= 1'b0;
      pix_valid_r <= 1'b0;
      pix_bit_r   <= 1'b0;
      col_busy_r  <= 1'b0;
      col_done_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      col_busy_r <= (state_s != IDLE);
      col_done_r <= (state_s == DONE);
      mem_en_r   <= pix_issue_s | col_issue_s;
      if (pix_issue_s)      mem_addr_r <= pix_addr_s;
      else if (col_issue_s) mem_addr_r <= cor_addr_s;
      else                  mem_addr_r <= mem_addr_r;
      tag_a_r     <= col_issue_s ? TAG_COL : TAG_PIX;
      idx_a_r     <= corner_r;
      rd_b_r      <= mem_en_r;
      tag_b_r     <= tag_a_r;
      idx_b_r     <= idx_a_r;
      pv1_r       <= pix_tick;
      pv2_r       <= pv1_r;
      pix_valid_r <= pv2_r;
      pix_bit_r   <= pv2_r & rd_b_r & (tag_b_r == TAG_PIX) & mem_rdata;
      if (accept_s) begin
        x0_r     <= {1'b0, col_x};
        y0_r     <= {1'b0, col_y};
        x1_r     <= x1_s;
        y1_r     <= y1_s;
        corner_r <= TL;
        hit_r    <= 4'd0;
      end else begin
        if (corner_adv_s) corner_r <= corner_r + 2'd1;
        if (corner_adv_s && cor_oob_s) hit_r[corner_r] <= 1'b1;
        if (rd_b_r && tag_b_r == TAG_COL) hit_r[idx_b_r] <= mem_rdata;
      end
    end
  end

`ifdef MAP_ARB_STATS_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of collision issues pushed back by a pixel issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_r <= 16'd0;
    else if (col_blocked_s && stall_cnt_r != 16'hFFFF) stall_cnt_r <= stall_cnt_r + 16'd1;
    else stall_cnt_r <= stall_cnt_r;
  end

  assign col_stall_cnt = stall_cnt_r;
`endif

  assign pix_valid = pix_valid_r;
  assign pix_bit   = pix_bit_r;
  assign col_busy  = col_busy_r;
  assign col_done  = col_done_r;
  assign col_hit   = hit_r;
  assign mem_en    = mem_en_r;
  assign mem_addr  = mem_addr_r;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed bench for map_port_arbiter with a behavioural single-port map memory.
module tb_map_port_arbiter;

  localparam int AW = 14;
  localparam int CW = 10;

  logic clk, rst_n, pix_tick, map_on, col_req, mem_rdata;
  logic [CW-1:0] pix_x, pix_y, col_x, col_y, col_w, col_h;
  logic pix_valid, pix_bit, col_busy, col_done, mem_en;
  logic [3:0] col_hit;
  logic [AW-1:0] mem_addr;
`ifdef MAP_ARB_STATS_EN
  logic [15:0] col_stall_cnt;
`endif

  logic map_mem [0:16383];
  int n_cmp = 0;
  int n_err = 0;
  int en_addr[$];
  int en_cyc[$];
  int done_at;

  map_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .pix_x(pix_x), .pix_y(pix_y),
    .map_on(map_on), .pix_valid(pix_valid), .pix_bit(pix_bit), .col_req(col_req),
    .col_x(col_x), .col_y(col_y), .col_w(col_w), .col_h(col_h), .col_busy(col_busy),
    .col_done(col_done), .col_hit(col_hit), .mem_en(mem_en), .mem_addr(mem_addr),
`ifdef MAP_ARB_STATS_EN
    .col_stall_cnt(col_stall_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem_en ? map_mem[mem_addr] : 1'b0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pix_probe(input string tag, input int x, input int y, input bit on,
                           input bit exp_en, input int exp_addr, input bit exp_bit);
    pix_x = CW'(x); pix_y = CW'(y); map_on = on; pix_tick = 1'b1;
    tick();
    pix_tick = 1'b0;
    check({tag, "_en"}, 32'(mem_en), 32'(exp_en));
    if (exp_en) check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    tick();
    check({tag, "_pv_early"}, 32'(pix_valid), 32'd0);
    tick();
    check({tag, "_pv"}, 32'(pix_valid), 32'd1);
    check({tag, "_bit"}, 32'(pix_bit), 32'(exp_bit));
    tick();
  endtask

  task automatic run_probe(input int x, input int y, input int w, input int h, input bit hold_req);
    en_addr.delete(); en_cyc.delete(); done_at = -1;
    col_x = CW'(x); col_y = CW'(y); col_w = CW'(w); col_h = CW'(h); col_req = 1'b1;
    tick();
    if (hold_req) col_x = CW'(50); else col_req = 1'b0;
    check("busy_rise", 32'(col_busy), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      if (mem_en) begin en_addr.push_back(int'(mem_addr)); en_cyc.push_back(i); end
      if (col_done) begin done_at = i; break; end
      col_req = 1'b0;
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 16384; a++) map_mem[a] = 1'b0;
    map_mem[305] = 1'b1; map_mem[1010] = 1'b1; map_mem[1414] = 1'b1; map_mem[3020] = 1'b1;
    rst_n = 1'b0; pix_tick = 1'b0; map_on = 1'b0; col_req = 1'b0;
    pix_x = '0; pix_y = '0; col_x = '0; col_y = '0; col_w = '0; col_h = '0;

    // 1: reset state
    tick(); tick(); tick();
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_bit", 32'(pix_bit), 32'd0);
    check("rst_busy", 32'(col_busy), 32'd0);
    check("rst_done", 32'(col_done), 32'd0);
    check("rst_hit", 32'(col_hit), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_busy", 32'(col_busy), 32'd0);
    check("rel_mem_en", 32'(mem_en), 32'd0);

    // 2/3: pixel path
    pix_probe("pix53", 5, 3, 1'b1, 1'b1, 305, 1'b1);
    pix_probe("pix63", 6, 3, 1'b1, 1'b1, 306, 1'b0);
    pix_probe("pix_oobx", 100, 3, 1'b1, 1'b0, 0, 1'b0);
    pix_probe("pix_off", 5, 3, 1'b0, 1'b0, 0, 1'b0);

    // 4: plain probe, col_req held into busy must be ignored
    run_probe(10, 10, 5, 5, 1'b1);
    check("t4_en_cnt", 32'(en_addr.size()), 32'd4);
    if (en_addr.size() == 4) begin
      check("t4_addr0", 32'(en_addr[0]), 32'd1010);
      check("t4_addr1", 32'(en_addr[1]), 32'd1014);
      check("t4_addr2", 32'(en_addr[2]), 32'd1410);
      check("t4_addr3", 32'(en_addr[3]), 32'd1414);
      check("t4_cyc_first", 32'(en_cyc[0]), 32'd2);
      check("t4_cyc_last", 32'(en_cyc[3]), 32'd5);
    end
    check("t4_done_at", 32'(done_at), 32'd7);
    check("t4_hit", 32'(col_hit), 32'd9);
    check("t4_busy_at_done", 32'(col_busy), 32'd1);
    tick();
    check("t4_busy_drop", 32'(col_busy), 32'd0);
    check("t4_done_pulse", 32'(col_done), 32'd0);
    tick();
    check("t4_hit_hold", 32'(col_hit), 32'd9);

    // 5: right edge probe, h = 0
    run_probe(95, 95, 10, 0, 1'b0);
    check("t5_en_cnt", 32'(en_addr.size()), 32'd2);
    if (en_addr.size() == 2) begin
      check("t5_addr0", 32'(en_addr[0]), 32'd9595);
      check("t5_addr1", 32'(en_addr[1]), 32'd9595);
    end
    check("t5_done_seen", 32'(done_at > 0), 32'd1);
    check("t5_hit", 32'(col_hit), 32'd10);
    tick(); tick();

    // 6: probe with pixel ticks every second cycle
    done_at = -1;
    col_x = CW'(10); col_y = CW'(10); col_w = CW'(5); col_h = CW'(5); pix_y = CW'(3); map_on = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i >= 1 && col_done && done_at < 0) done_at = i;
      check("t6_pv", 32'(pix_valid), 32'(i >= 3 && i <= 13 && (i % 2) == 1));
      if (i >= 3 && i <= 13 && (i % 2) == 1)
        check("t6_bit", 32'(pix_bit), 32'((((i - 3) / 2) % 2) == 0));
      pix_tick = (i <= 10) && ((i % 2) == 0);
      pix_x = (((i / 2) % 2) == 0) ? CW'(5) : CW'(6);
      col_req = (i == 0);
      tick();
    end
    pix_tick = 1'b0;
    check("t6_done_at", 32'(done_at), 32'd10);
    check("t6_hit", 32'(col_hit), 32'd9);
    check("t6_busy", 32'(col_busy), 32'd0);
`ifdef MAP_ARB_STATS_EN
    check("t6_stalls", 32'(col_stall_cnt), 32'd3);
`endif

    // 7: reset during DRAIN aborts the probe
    col_x = CW'(10); col_y = CW'(10); col_w = CW'(5); col_h = CW'(5); col_req = 1'b1;
    tick();
    col_req = 1'b0;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("t7_busy", 32'(col_busy), 32'd0);
    check("t7_done", 32'(col_done), 32'd0);
    check("t7_mem_en", 32'(mem_en), 32'd0);
    check("t7_hit", 32'(col_hit), 32'd0);
    tick();
    check("t7_done_hold", 32'(col_done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("t7_done_after", 32'(col_done), 32'd0);
    run_probe(20, 30, 1, 1, 1'b0);
    check("t7_en_cnt", 32'(en_addr.size()), 32'd4);
    if (en_addr.size() == 4) check("t7_addr3", 32'(en_addr[3]), 32'd3020);
    check("t7_done_at", 32'(done_at), 32'd7);
    check("t7_hit", 32'(col_hit), 32'd15);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
